// File: rtl/game_pkg.sv
// Shared game constants and types for the projectile throw path.
package game_pkg;
  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned SCREEN_H = 768;
  localparam int unsigned GROUND_Y = 600;
  localparam int unsigned COORD_W  = 12;
  localparam int unsigned FORCE_W  = 10;
  localparam int unsigned RGB_W    = 12;
  localparam int unsigned RAST_W   = 11;
  localparam int unsigned HOLD_W   = 8;

  typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} throw_state_t;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [6:0]                speed_x_t;
  typedef logic signed [7:0]         speed_y_t;
endpackage

// File: rtl/vga_if.sv
// VGA raster timing plus pixel colour between pipeline stages.
interface vga_if;
  import game_pkg::*;
  logic [RAST_W-1:0] hcount;
  logic [RAST_W-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              hblnk;
  logic              vblnk;
  logic [RGB_W-1:0]  rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/projectile_physics.sv
// Frame-step integrator: position/velocity registers and landing detection on the stepped result.
module projectile_physics import game_pkg::*; #(
  parameter int START_X  = 900,
  parameter int START_Y  = 380,
  parameter int GROUND_Y = 600,
  parameter int GRAVITY  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic       home,
  input  logic [7:0] force_hi,
  output coord_t     pos_x,
  output coord_t     pos_y,
  output logic       hit_ground_c,
  output logic       hit_oob_c
);
  localparam logic signed [12:0] GROUND13 = 13'(GROUND_Y);
  localparam logic signed [12:0] X_MAX    = 13'(SCREEN_W - 1);

  speed_x_t               vx;
  speed_y_t               vy;
  logic signed [12:0]     nx;
  logic signed [12:0]     ny;
  logic signed [8:0]      vy_sum;
  speed_y_t               vy_next;

  // Candidate next-frame state, using the current vy (explicit Euler).
  always_comb begin
    nx           = 13'(pos_x) - $signed({6'b000000, vx});
    ny           = 13'(pos_y) + 13'(vy);
    vy_sum       = 9'(vy) + 9'(GRAVITY);
    vy_next      = (vy_sum > 9'sd127) ? 8'sd127 : 8'(vy_sum);
    hit_ground_c = (ny >= GROUND13);
    hit_oob_c    = (nx < 13'sd0) || (nx > X_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= 12'(START_X);
      pos_y <= 12'(START_Y);
      vx    <= '0;
      vy    <= '0;
    end else if (load) begin
      pos_x <= 12'(START_X);
      pos_y <= 12'(START_Y);
      vx    <= force_hi[7:1];
      vy    <= 8'(-$signed({1'b0, force_hi}));
    end else if (home) begin
      pos_x <= 12'(START_X);
      pos_y <= 12'(START_Y);
      vx    <= '0;
      vy    <= '0;
    end else if (step) begin
      pos_x <= 12'(nx);
      pos_y <= hit_ground_c ? 12'(GROUND_Y) : 12'(ny);
      vy    <= vy_next;
    end
  end
endmodule

// File: rtl/throw_projectile.sv
// Launches a projectile on space release, tracks IDLE/FLIGHT/LANDED and overlays its sprite on the VGA stream.
module throw_projectile import game_pkg::*; #(
  parameter int             START_X     = 900,
  parameter int             START_Y     = 380,
  parameter int             GROUND_Y    = 600,
  parameter int             GRAVITY     = 1,
  parameter int             BALL_SIZE   = 8,
  parameter logic [11:0]    BALL_RGB    = 12'hFF0,
  parameter int             HOLD_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               space,
  input  logic [FORCE_W-1:0] throw_force,
  vga_if.slave               vga_in,
  vga_if.master              vga_out,
  output logic               in_flight,
  output logic               landed,
  output logic               out_of_bounds,
  output coord_t             pos_x,
  output coord_t             pos_y
);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic signed [12:0] BS        = 13'(BALL_SIZE);

  throw_state_t      state;
  logic              space_prev;
  logic              launch_pend;
  logic              vblnk_prev;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tick_c;
  logic              load_c;
  logic              step_c;
  logic              home_c;
  logic              hit_ground_c;
  logic              hit_oob_c;
  logic              sprite_on_c;
  logic signed [12:0] hc, vc, px, py;

  always_comb begin
    tick_c = vga_in.vblnk & ~vblnk_prev;
    load_c = launch_pend && (state == IDLE) && (throw_force != '0);
    step_c = tick_c && (state == FLIGHT);
    home_c = tick_c && (state == LANDED) && (hold_cnt == HOLD_LAST);
  end

  projectile_physics #(
    .START_X (START_X),
    .START_Y (START_Y),
    .GROUND_Y(GROUND_Y),
    .GRAVITY (GRAVITY)
  ) u_phys (
    .clk         (clk),
    .rst         (rst),
    .load        (load_c),
    .step        (step_c),
    .home        (home_c),
    .force_hi    (throw_force[9:2]),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .hit_ground_c(hit_ground_c),
    .hit_oob_c   (hit_oob_c)
  );

  // Release detect, frame tick edge and throw FSM; force is sampled one cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      space_prev    <= 1'b0;
      launch_pend   <= 1'b0;
      vblnk_prev    <= 1'b0;
      hold_cnt      <= '0;
      in_flight     <= 1'b0;
      landed        <= 1'b0;
      out_of_bounds <= 1'b0;
    end else begin
      space_prev  <= space;
      launch_pend <= space_prev & ~space;
      vblnk_prev  <= vga_in.vblnk;
      landed      <= 1'b0;
      case (state)
        IDLE: begin
          if (load_c) begin
            state         <= FLIGHT;
            in_flight     <= 1'b1;
            out_of_bounds <= 1'b0;
          end
        end
        FLIGHT: begin
          if (step_c && (hit_ground_c || hit_oob_c)) begin
            state         <= LANDED;
            in_flight     <= 1'b0;
            landed        <= 1'b1;
            hold_cnt      <= '0;
            out_of_bounds <= ~hit_ground_c;
          end
        end
        LANDED: begin
          if (home_c) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (tick_c) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sprite overlay; timing passes straight through.
  always_comb begin
    hc = $signed({2'b00, vga_in.hcount});
    vc = $signed({2'b00, vga_in.vcount});
    px = 13'(pos_x);
    py = 13'(pos_y);
    sprite_on_c = (state != IDLE) && !out_of_bounds &&
                  (hc >= px) && (hc < px + BS) &&
                  (vc >= py) && (vc < py + BS);
  end

  assign vga_out.hcount = vga_in.hcount;
  assign vga_out.vcount = vga_in.vcount;
  assign vga_out.hsync  = vga_in.hsync;
  assign vga_out.vsync  = vga_in.vsync;
  assign vga_out.hblnk  = vga_in.hblnk;
  assign vga_out.vblnk  = vga_in.vblnk;
  assign vga_out.rgb    = sprite_on_c ? BALL_RGB : vga_in.rgb;
endmodule

// File: tb/tb_throw_projectile.sv
// Self-checking bench for throw_projectile: vector table, corner sequences and randomized flights vs a frame model.
module tb_throw_projectile;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        space = 1'b0;
  logic [9:0]  throw_force = '0;
  logic        in_flight, landed, out_of_bounds;
  logic        in_flight2, landed2, out_of_bounds2;
  coord_t      pos_x, pos_y, pos_x2, pos_y2;

  vga_if vin();
  vga_if vout1();
  vga_if vout2();

  throw_projectile u_dut (
    .clk(clk), .rst(rst), .space(space), .throw_force(throw_force),
    .vga_in(vin.slave), .vga_out(vout1.master),
    .in_flight(in_flight), .landed(landed), .out_of_bounds(out_of_bounds),
    .pos_x(pos_x), .pos_y(pos_y));

  throw_projectile #(.START_X(20)) u_dut2 (
    .clk(clk), .rst(rst), .space(space), .throw_force(throw_force),
    .vga_in(vin.slave), .vga_out(vout2.master),
    .in_flight(in_flight2), .landed(landed2), .out_of_bounds(out_of_bounds2),
    .pos_x(pos_x2), .pos_y(pos_y2));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int land_cnt = 0;
  int land_cnt2 = 0;

  always @(negedge clk) begin
    if (landed)  land_cnt  <= land_cnt + 1;
    if (landed2) land_cnt2 <= land_cnt2 + 1;
  end

  // Frame-level reference model for the default-parameter instance.
  int m_mode, m_x, m_y, m_vx, m_vy, m_hold, m_oob, m_lands;

  task automatic m_reset();
    m_mode = 0; m_x = 900; m_y = 380; m_vx = 0; m_vy = 0; m_hold = 0; m_oob = 0;
  endtask

  task automatic m_launch(input int f);
    if (m_mode == 0 && f != 0) begin
      m_mode = 1; m_x = 900; m_y = 380; m_vx = f / 8; m_vy = -(f / 4); m_oob = 0;
    end
  endtask

  task automatic m_tick();
    if (m_mode == 1) begin
      m_x = m_x - m_vx;
      m_y = m_y + m_vy;
      m_vy = (m_vy + 1 > 127) ? 127 : m_vy + 1;
      if (m_y >= 600) begin
        m_y = 600; m_mode = 2; m_hold = 0; m_lands++;
      end else if (m_x < 0 || m_x > 1023) begin
        m_mode = 2; m_hold = 0; m_oob = 1; m_lands++;
      end
    end else if (m_mode == 2) begin
      if (m_hold == 59) begin
        m_mode = 0; m_x = 900; m_y = 380; m_vx = 0; m_vy = 0;
      end else m_hold++;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
  endtask

  task automatic throw_key(input int f);
    @(negedge clk); space = 1'b1;
    @(negedge clk);
    @(negedge clk); space = 1'b0; throw_force = 10'(f);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk); vin.vblnk = 1'b1;
    @(negedge clk); vin.vblnk = 1'b0;
  endtask

  task automatic raster(input int h, input int v);
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    #1;
  endtask

  typedef struct {
    int   f;
    int   n;
    int   ex;
    int   ey;
    int   efl;
  } vec_t;

  vec_t vecs[7];
  int   n, lc0, lc2, ml0, f, guard;

  initial begin
    vecs[0] = '{f: 64,  n: 1, ex: 892, ey: 364, efl: 1};
    vecs[1] = '{f: 64,  n: 2, ex: 884, ey: 349, efl: 1};
    vecs[2] = '{f: 0,   n: 3, ex: 900, ey: 380, efl: 0};
    vecs[3] = '{f: 8,   n: 3, ex: 897, ey: 377, efl: 1};
    vecs[4] = '{f: 128, n: 1, ex: 884, ey: 348, efl: 1};
    vecs[5] = '{f: 100, n: 2, ex: 876, ey: 331, efl: 1};
    vecs[6] = '{f: 3,   n: 2, ex: 900, ey: 381, efl: 1};

    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h123;
    m_lands = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_flight", int'(in_flight), 0);
    chk("rst_landed", int'(landed), 0);
    chk("rst_oob", int'(out_of_bounds), 0);
    chk("rst_x", pos_x, 900);
    chk("rst_y", pos_y, 380);
    chk("rst_x2", pos_x2, 20);
    vin.hsync = 1'b1; #1;
    chk("pass_hsync", int'(vout1.hsync), 1);
    vin.hsync = 1'b0;

    // Vector table: single launch followed by a fixed number of frames
    for (int i = 0; i < 7; i++) begin
      do_reset();
      lc0 = land_cnt;
      throw_key(vecs[i].f);
      repeat (vecs[i].n) tick();
      chk($sformatf("vec%0d_x", i), pos_x, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), pos_y, vecs[i].ey);
      chk($sformatf("vec%0d_fl", i), int'(in_flight), vecs[i].efl);
      @(negedge clk);
      chk($sformatf("vec%0d_nolanded", i), land_cnt - lc0, 0);
    end

    // Full flight to ground, hold, return home
    do_reset();
    lc0 = land_cnt;
    throw_key(64);
    chk("t2_launch", int'(in_flight), 1);
    n = 0;
    while (in_flight && n < 100) begin tick(); n++; end
    chk("t2_ticks", n, 44);
    chk("t2_y", pos_y, 600);
    chk("t2_x", pos_x, 548);
    chk("t2_oob", int'(out_of_bounds), 0);
    raster(548, 600); chk("t2_sprite_landed", int'(vout1.rgb), 'hFF0);
    repeat (59) tick();
    chk("t2_hold_x", pos_x, 548);
    raster(550, 603); chk("t2_sprite_hold", int'(vout1.rgb), 'hFF0);
    tick();
    chk("t2_home_x", pos_x, 900);
    chk("t2_home_y", pos_y, 380);
    raster(900, 380); chk("t2_idle_hidden", int'(vout1.rgb), 'h123);
    chk("t2_one_landed", land_cnt - lc0, 1);

    // Release during flight is ignored
    do_reset();
    throw_key(64); m_launch(64);
    repeat (3) begin tick(); m_tick(); end
    throw_key(32);
    repeat (3) begin tick(); m_tick(); end
    chk("t4_x", pos_x, m_x);
    chk("t4_y", pos_y, m_y);
    chk("t4_x_const", pos_x, 852);
    chk("t4_y_const", pos_y, 299);

    // Leaving the screen on the left (START_X=20 instance)
    do_reset();
    lc2 = land_cnt2;
    throw_key(128);
    tick();
    chk("t5_x1", pos_x2, 4);
    chk("t5_fl1", int'(in_flight2), 1);
    raster(4, 348); chk("t5_sprite_on", int'(vout2.rgb), 'hFF0);
    tick();
    chk("t5_x2", pos_x2, -12);
    chk("t5_oob", int'(out_of_bounds2), 1);
    chk("t5_fl2", int'(in_flight2), 0);
    raster(0, 317); chk("t5_hidden", int'(vout2.rgb), 'h123);
    @(negedge clk);
    chk("t5_landed", land_cnt2 - lc2, 1);

    // Overlay box at launch point, then asynchronous reset mid-flight
    do_reset();
    throw_key(64);
    raster(900, 380); chk("t6_tl", int'(vout1.rgb), 'hFF0);
    raster(907, 387); chk("t6_br", int'(vout1.rgb), 'hFF0);
    raster(908, 380); chk("t6_right", int'(vout1.rgb), 'h123);
    raster(899, 380); chk("t6_left", int'(vout1.rgb), 'h123);
    raster(900, 388); chk("t6_below", int'(vout1.rgb), 'h123);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_fl", int'(in_flight), 0);
    chk("t6_rst_x", pos_x, 900);
    chk("t6_rst_y", pos_y, 380);
    @(negedge clk); rst = 1'b0;
    m_reset();

    // Randomized launches checked frame by frame against the model
    for (int t = 0; t < 16; t++) begin
      f = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 128));
      lc0 = land_cnt; ml0 = m_lands;
      throw_key(f); m_launch(f);
      chk("rnd_launch", int'(in_flight), int'(m_mode == 1));
      guard = 0;
      while (m_mode != 0 && guard < 400) begin
        tick(); m_tick(); guard++;
        chk("rnd_x", pos_x, m_x);
        chk("rnd_y", pos_y, m_y);
        chk("rnd_fl", int'(in_flight), int'(m_mode == 1));
        chk("rnd_oob", int'(out_of_bounds), m_oob);
      end
      if (guard >= 400) chk("rnd_timeout", guard, 0);
      repeat (2) @(negedge clk);
      chk("rnd_lands", land_cnt - lc0, m_lands - ml0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
